// File: rtl/booth2_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
package booth2_pkg;

  // Bit positions of the decoded Booth control vector
  localparam int unsigned CTL_SINGLE = 0;
  localparam int unsigned CTL_DOUBLE = 1;
  localparam int unsigned CTL_NEG    = 2;
  localparam int unsigned CTL_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth digits needed: unsigned operands need one more to absorb the zero-extended MSB
  function automatic int unsigned ndigits(input int unsigned width, input logic is_signed);
    return is_signed ? (width / 2) : (width / 2 + 1);
  endfunction

endpackage

// File: rtl/booth2_pp_gen.sv
// Booth-2 partial-product generator: one's-complement multiple of x plus a negate flag.
module booth2_pp_gen
  import booth2_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic [2:0]   digit,
  input  logic [W-1:0] x,
  output logic [W-1:0] pp,
  output logic         neg
);

  logic [CTL_W-1:0] ctl_c;

  // Decode the digit and select 0, x or 2x, inverted when negative
  always_comb begin
    ctl_c             = '0;
    ctl_c[CTL_SINGLE] = digit[0] ^ digit[1];
    ctl_c[CTL_DOUBLE] = ~ctl_c[CTL_SINGLE] & (digit[1] ^ digit[2]);
    ctl_c[CTL_NEG]    = digit[2];
    pp  = (({W{ctl_c[CTL_SINGLE]}} & x) | ({W{ctl_c[CTL_DOUBLE]}} & (x << 1)))
          ^ {W{ctl_c[CTL_NEG]}};
    neg = ctl_c[CTL_NEG];
  end

endmodule

// File: rtl/booth2_seq_multiplier.sv
// Iterative radix-4 Booth multiplier retiring one digit per clock, valid/ready on both sides.
module booth2_seq_multiplier
  import booth2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int unsigned XW    = WIDTH + 2;
  localparam int unsigned BW    = WIDTH + 3;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH / 2 + 2);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth2_seq_multiplier: WIDTH must be even and >= 4");
  end

  state_e            state_q, state_d;
  logic [XW-1:0]     a_ext_q, a_ext_d;
  logic [BW-1:0]     b_ext_q, b_ext_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              signed_q, signed_d;
  logic              out_valid_q, out_valid_d;
  logic [PW-1:0]     out_p_q, out_p_d;
  logic              busy_q, busy_d;

  logic [2:0]        digit_c;
  logic [XW-1:0]     pp_c;
  logic              neg_c;
  logic [PW-1:0]     pp_sext_c;
  logic [PW-1:0]     sum_c;
  logic              last_c;
  logic              accept_c;
  logic              ext_a_c, ext_b_c;

  booth2_pp_gen #(.W(XW)) u_pp_gen (
    .digit (digit_c),
    .x     (a_ext_q),
    .pp    (pp_c),
    .neg   (neg_c)
  );

  // Input readiness: idle, or done with the result being consumed this cycle
  always_comb begin
    in_ready = ~rst & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    accept_c = in_valid & in_ready;
  end

  // Datapath: current digit, sign-extended partial product and accumulator sum
  always_comb begin
    digit_c   = 3'(b_ext_q >> {cnt_q, 1'b0});
    pp_sext_c = {{(PW - XW){pp_c[XW-1]}}, pp_c};
    sum_c     = acc_q + (pp_sext_c << {cnt_q, 1'b0}) + (PW'(neg_c) << {cnt_q, 1'b0});
    last_c    = (cnt_q == CNT_W'(ndigits(WIDTH, signed_q) - 1));
    ext_a_c   = in_signed & in_a[WIDTH-1];
    ext_b_c   = in_signed & in_b[WIDTH-1];
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    a_ext_d     = a_ext_q;
    b_ext_d     = b_ext_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: ;
      CALC: begin
        acc_d = sum_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_p_d     = sum_c;
          busy_d      = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      a_ext_d  = {{2{ext_a_c}}, in_a};
      b_ext_d  = {{2{ext_b_c}}, in_b, 1'b0};
      acc_d    = '0;
      cnt_d    = '0;
      signed_d = in_signed;
      state_d  = CALC;
      busy_d   = 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_ext_q     <= '0;
      b_ext_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_ext_q     <= a_ext_d;
      b_ext_q     <= b_ext_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth2_seq_multiplier.sv
// Directed and random checks of the Booth-2 sequential multiplier at WIDTH 4, 8 and 16.
module tb_booth2_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sg;
  logic iv4, ir4, ov4, or4, bz4;  logic [3:0]  a4, b4;  logic [7:0]  p4;
  logic iv8, ir8, ov8, or8, bz8;  logic [7:0]  a8, b8;  logic [15:0] p8;
  logic iv16, ir16, ov16, or16, bz16; logic [15:0] a16, b16; logic [31:0] p16;

  int n_cmp = 0;
  int n_bad = 0;

  booth2_seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_signed(sg), .out_valid(ov4), .out_ready(or4), .out_p(p4), .busy(bz4));

  booth2_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(sg), .out_valid(ov8), .out_ready(or8), .out_p(p8), .busy(bz8));

  booth2_seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_signed(sg), .out_valid(ov16), .out_ready(or16), .out_p(p16), .busy(bz16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer a pair to the 8-bit instance, then count negedges until out_valid
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; sg = s; iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    check("send8_ready", 32'(ir8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    check("calc_busy", 32'(bz8), 32'd1);
    check("calc_ready", 32'(ir8), 32'd0);
    lat = 0;
    while (!ov8 && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic take8();
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    check("valid_drop", 32'(ov8), 32'd0);
  endtask

  function automatic logic [33:0] peek(input int w);
    case (w)
      4:       return {ov4, ir4, 24'd0, p4};
      8:       return {ov8, ir8, 16'd0, p8};
      default: return {ov16, ir16, p16};
    endcase
  endfunction

  task automatic drive(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic v, input logic r);
    case (w)
      4:       begin a4 = a[3:0]; b4 = b[3:0]; iv4 = v; or4 = r; end
      8:       begin a8 = a[7:0]; b8 = b[7:0]; iv8 = v; or8 = r; end
      default: begin a16 = a;     b16 = b;     iv16 = v; or16 = r; end
    endcase
  endtask

  // One random transaction on the instance of width w against an integer reference
  task automatic rand_txn(input int w);
    logic [15:0] ra, rb;
    logic        s;
    longint      av, bv, mask;
    logic [33:0] pk;
    logic [31:0] exp;
    int          n;
    mask = (longint'(1) << w) - 1;
    ra = 16'($urandom) & 16'(mask);
    rb = 16'($urandom) & 16'(mask);
    s  = 1'($urandom);
    av = longint'(ra);
    bv = longint'(rb);
    if (s && ra[w-1]) av = av - (longint'(1) << w);
    if (s && rb[w-1]) bv = bv - (longint'(1) << w);
    exp = 32'((av * bv) & ((longint'(1) << (2 * w)) - 1));
    @(negedge clk);
    sg = s;
    drive(w, ra, rb, 1'b1, 1'b0);
    pk = peek(w);
    if (!pk[32]) check($sformatf("rand_w%0d_ready", w), 32'(pk[32]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(w, ra, rb, 1'b0, 1'b0);
    n = 0;
    pk = peek(w);
    while (!pk[33] && n < 50) begin @(negedge clk); n++; pk = peek(w); end
    check($sformatf("rand_w%0d_%s_%0h_%0h", w, s ? "s" : "u", ra, rb), pk[31:0], exp);
    drive(w, ra, rb, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(w, ra, rb, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; sg = 1'b0;
    iv4 = 0; or4 = 0; a4 = '0; b4 = '0;
    iv8 = 0; or8 = 0; a8 = '0; b8 = '0;
    iv16 = 0; or16 = 0; a16 = '0; b16 = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_out_p", 32'(p8), 32'd0);
    check("rst_busy", 32'(bz8), 32'd0);
    check("rst_in_ready", 32'(ir8), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(ir8), 32'd1);

    // Signed extremes
    send8(8'h80, 8'h80, 1'b1, lat);
    check("s_m128sq_p", 32'(p8), 32'h4000);
    check("s_m128sq_lat", 32'(lat), 32'd4);
    take8();

    send8(8'hFF, 8'hFF, 1'b0, lat);
    check("u_255sq_p", 32'(p8), 32'hFE01);
    check("u_255sq_lat", 32'(lat), 32'd5);
    take8();

    send8(8'hFF, 8'hFF, 1'b1, lat);
    check("s_m1sq_p", 32'(p8), 32'h0001);
    check("s_m1sq_lat", 32'(lat), 32'd4);
    take8();

    // Result held under backpressure while inputs wiggle
    send8(8'h7F, 8'h80, 1'b1, lat);
    check("s_127xm128_p", 32'(p8), 32'hC080);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a8 = 8'(i * 37); b8 = 8'(i * 11); sg = 1'(i);
      check("hold_p", 32'(p8), 32'hC080);
      check("hold_valid", 32'(ov8), 32'd1);
      check("hold_ready", 32'(ir8), 32'd0);
    end
    take8();

    // Back-to-back: second pair accepted on the first product's handshake edge
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; sg = 1'b1; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hF9; b8 = 8'd9;
    lat = 0;
    while (!ov8 && lat < 50) begin @(negedge clk); lat++; end
    check("b2b_first_p", 32'(p8), 32'h000F);
    check("b2b_first_lat", 32'(lat), 32'd4);
    check("b2b_ready_done", 32'(ir8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    check("b2b_valid_drop", 32'(ov8), 32'd0);
    check("b2b_busy", 32'(bz8), 32'd1);
    lat = 0;
    while (!ov8 && lat < 50) begin @(negedge clk); lat++; end
    check("b2b_second_p", 32'(p8), 32'hFFC1);
    check("b2b_second_lat", 32'(lat), 32'd4);
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    check("b2b_idle_valid", 32'(ov8), 32'd0);

    // Reset during the second CALC cycle discards the transaction
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; sg = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(ov8), 32'd0);
    check("midrst_busy", 32'(bz8), 32'd0);
    rst = 1'b0;
    or8 = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_output", 32'(ov8), 32'd0);
    or8 = 1'b0;
    send8(8'd2, 8'd3, 1'b1, lat);
    check("post_rst_p", 32'(p8), 32'h0006);
    check("post_rst_lat", 32'(lat), 32'd4);
    take8();

    // Random sweep across widths
    for (int i = 0; i < 1000; i++) rand_txn(4);
    for (int i = 0; i < 1000; i++) rand_txn(8);
    for (int i = 0; i < 1000; i++) rand_txn(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
